// File: rtl/highlight_frame_scheduler_if.sv
// Request/acknowledge bus shared by the keypad (KEY) and checkout (CHK) requesters.
// The master side raises req with op/idx; the slave side answers with a one-cycle ack.
interface highlight_frame_scheduler_if;
  logic       key_req;
  logic [1:0] key_op;
  logic [3:0] key_idx;
  logic       key_ack;
  logic       chk_req;
  logic [1:0] chk_op;
  logic [3:0] chk_idx;
  logic       chk_ack;
  logic       idx_err;

  modport master (
    output key_req, key_op, key_idx, chk_req, chk_op, chk_idx,
    input  key_ack, chk_ack, idx_err
  );

  modport slave (
    input  key_req, key_op, key_idx, chk_req, chk_op, chk_idx,
    output key_ack, chk_ack, idx_err
  );
endinterface

// File: rtl/highlight_frame_scheduler.sv
// Arbitrates highlight-mask edits from KEY and CHK into a shadow mask and commits it
// to the VGA highlight list only on a frame boundary; also produces a frame-counted blink.
module highlight_frame_scheduler #(
  parameter int NUM_PRODUCTS = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    VGA_VS,
  highlight_frame_scheduler_if.slave req_bus,
  output logic [NUM_PRODUCTS-1:0] HighlightedProductList,
  output logic                    blink_phase,
  output logic                    pending
);

  typedef enum logic [1:0] {IDLE, APPLY, WAIT_DROP} state_t;

  state_t                  state, state_next;
  logic                    rr_last;
  logic                    grant_key;
  logic [1:0]              lat_op;
  logic [3:0]              lat_idx;
  logic [NUM_PRODUCTS-1:0] shadow, shadow_next, bit_mask;
  logic                    vs_s1, vs_s2, vs_d, frame_edge;
  logic [7:0]              frame_cnt;
  logic                    pick_key, granted_req, idx_bad, any_req;
  logic                    key_ack_next, chk_ack_next, idx_err_next;

  // rr_last = 1 means CHK was granted last, so KEY takes the next tie
  assign any_req     = req_bus.key_req | req_bus.chk_req;
  assign pick_key    = req_bus.key_req & (~req_bus.chk_req | rr_last);
  assign granted_req = grant_key ? req_bus.key_req : req_bus.chk_req;
  assign idx_bad     = (lat_op != 2'b11) && (32'(lat_idx) >= 32'(NUM_PRODUCTS));
  assign frame_edge  = vs_d & ~vs_s2;
  assign pending     = (shadow != HighlightedProductList);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (any_req) state_next = APPLY;
      APPLY:     state_next = WAIT_DROP;
      WAIT_DROP: if (!granted_req) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    shadow_next  = shadow;
    key_ack_next = 1'b0;
    chk_ack_next = 1'b0;
    idx_err_next = 1'b0;
    bit_mask     = {{(NUM_PRODUCTS-1){1'b0}}, 1'b1} << lat_idx;
    if (state == APPLY) begin
      key_ack_next = grant_key;
      chk_ack_next = ~grant_key;
      idx_err_next = idx_bad;
      if (!idx_bad) begin
        case (lat_op)
          2'b00:   shadow_next = shadow | bit_mask;
          2'b01:   shadow_next = shadow & ~bit_mask;
          2'b10:   shadow_next = shadow ^ bit_mask;
          default: shadow_next = '0;
        endcase
      end
    end
  end

  // Grant latch, shadow/ack registers, VS synchronizer, commit and blink counter
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      rr_last                <= 1'b0;
      grant_key              <= 1'b0;
      lat_op                 <= 2'b00;
      lat_idx                <= 4'd0;
      shadow                 <= '0;
      req_bus.key_ack        <= 1'b0;
      req_bus.chk_ack        <= 1'b0;
      req_bus.idx_err        <= 1'b0;
      vs_s1                  <= 1'b0;
      vs_s2                  <= 1'b0;
      vs_d                   <= 1'b0;
      HighlightedProductList <= '0;
      frame_cnt              <= 8'd0;
      blink_phase            <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_key <= pick_key;
        lat_op    <= pick_key ? req_bus.key_op  : req_bus.chk_op;
        lat_idx   <= pick_key ? req_bus.key_idx : req_bus.chk_idx;
      end
      if (state == APPLY) rr_last <= ~grant_key;
      shadow          <= shadow_next;
      req_bus.key_ack <= key_ack_next;
      req_bus.chk_ack <= chk_ack_next;
      req_bus.idx_err <= idx_err_next;
      vs_s1           <= VGA_VS;
      vs_s2           <= vs_s1;
      vs_d            <= vs_s2;
      // Commit samples the shadow before any same-edge edit lands
      if (frame_edge) begin
        HighlightedProductList <= shadow;
        if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= 8'd0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_highlight_frame_scheduler.sv
// Self-checking bench for highlight_frame_scheduler: directed sequences, a vector table
// and randomized requests compared against a transaction-level mask model.
module tb_highlight_frame_scheduler;
  localparam int NP = 12;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vga_vs;
  logic [NP-1:0] list;
  logic          blink;
  logic          pend;

  highlight_frame_scheduler_if bus ();

  highlight_frame_scheduler #(.NUM_PRODUCTS(NP), .BLINK_FRAMES(BF)) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .VGA_VS(vga_vs),
    .req_bus(bus),
    .HighlightedProductList(list),
    .blink_phase(blink),
    .pending(pend)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NP-1:0] m_shadow;
  logic [NP-1:0] m_list;
  bit            m_last_chk;
  int            m_frames;

  typedef struct {
    bit         use_chk;
    logic [1:0] op;
    logic [3:0] idx;
    bit         exp_err;
    logic [11:0] exp_mask;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic kr, input logic [1:0] kop, input logic [3:0] kidx,
                               input logic cr, input logic [1:0] cop, input logic [3:0] cidx);
    bus.key_req = kr;  bus.key_op = kop; bus.key_idx = kidx;
    bus.chk_req = cr;  bus.chk_op = cop; bus.chk_idx = cidx;
  endtask

  // Mask edit semantics at transaction level; returns whether the index was rejected
  function automatic bit modelApply(input logic [1:0] op, input logic [3:0] idx);
    if (op == 2'b11) begin
      m_shadow = '0;
      return 1'b0;
    end
    if (int'(idx) >= NP) return 1'b1;
    case (op)
      2'b00:   m_shadow[idx] = 1'b1;
      2'b01:   m_shadow[idx] = 1'b0;
      default: m_shadow[idx] = ~m_shadow[idx];
    endcase
    return 1'b0;
  endfunction

  task automatic modelReset();
    m_shadow = '0; m_list = '0; m_last_chk = 1'b0; m_frames = 0;
  endtask

  task automatic singleReq(input bit use_chk, input logic [1:0] op, input logic [3:0] idx, output logic err_seen);
    bit e;
    if (use_chk) applyStimulus(0, 2'b00, 4'd0, 1, op, idx);
    else         applyStimulus(1, op, idx, 0, 2'b00, 4'd0);
    tick();
    checkOutput("ack_early", {bus.key_ack, bus.chk_ack}, 0);
    tick();
    e = modelApply(op, idx);
    m_last_chk = use_chk;
    checkOutput(use_chk ? "chk_ack" : "key_ack", {bus.key_ack, bus.chk_ack}, use_chk ? 1 : 2);
    checkOutput("idx_err", bus.idx_err, e);
    checkOutput("pending", pend, m_shadow != m_list);
    err_seen = bus.idx_err;
    applyStimulus(0, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    tick();
    checkOutput("ack_gone", {bus.key_ack, bus.chk_ack, bus.idx_err}, 0);
  endtask

  task automatic tieReq(input logic [1:0] kop, input logic [3:0] kidx, input logic [1:0] cop, input logic [3:0] cidx);
    bit first_chk;
    bit e;
    first_chk = !m_last_chk;
    applyStimulus(1, kop, kidx, 1, cop, cidx);
    tick();
    tick();
    e = first_chk ? modelApply(cop, cidx) : modelApply(kop, kidx);
    m_last_chk = first_chk;
    checkOutput("tie_first_ack", {bus.key_ack, bus.chk_ack}, first_chk ? 1 : 2);
    checkOutput("tie_first_err", bus.idx_err, e);
    if (first_chk) bus.chk_req = 1'b0;
    else           bus.key_req = 1'b0;
    tick();
    checkOutput("tie_gap", {bus.key_ack, bus.chk_ack}, 0);
    tick();
    tick();
    e = first_chk ? modelApply(kop, kidx) : modelApply(cop, cidx);
    m_last_chk = !first_chk;
    checkOutput("tie_second_ack", {bus.key_ack, bus.chk_ack}, first_chk ? 2 : 1);
    checkOutput("tie_second_err", bus.idx_err, e);
    checkOutput("tie_pending", pend, m_shadow != m_list);
    applyStimulus(0, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    tick();
  endtask

  task automatic framePulse();
    vga_vs = 1'b0;
    repeat (4) tick();
    vga_vs = 1'b1;
    repeat (4) tick();
    m_list = m_shadow;
    m_frames++;
  endtask

  task automatic checkFrame();
    checkOutput("list", list, m_list);
    checkOutput("pending_after_frame", pend, 0);
    checkOutput("blink", blink, (m_frames / BF) % 2);
  endtask

  initial begin
    logic e;
    vecs[0] = '{1'b0, 2'b00, 4'd0,  1'b0, 12'h001};
    vecs[1] = '{1'b1, 2'b00, 4'd11, 1'b0, 12'h801};
    vecs[2] = '{1'b0, 2'b10, 4'd0,  1'b0, 12'h800};
    vecs[3] = '{1'b1, 2'b10, 4'd7,  1'b0, 12'h880};
    vecs[4] = '{1'b0, 2'b01, 4'd11, 1'b0, 12'h080};
    vecs[5] = '{1'b1, 2'b00, 4'd12, 1'b1, 12'h080};
    vecs[6] = '{1'b0, 2'b01, 4'd15, 1'b1, 12'h080};
    vecs[7] = '{1'b0, 2'b11, 4'd13, 1'b0, 12'h000};
    vecs[8] = '{1'b1, 2'b00, 4'd2,  1'b0, 12'h004};
    vecs[9] = '{1'b0, 2'b10, 4'd11, 1'b0, 12'h804};

    rst_n  = 1'b0;
    vga_vs = 1'b1;
    applyStimulus(0, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    modelReset();
    repeat (3) tick();
    checkOutput("reset_list", list, 0);
    checkOutput("reset_blink", blink, 0);
    checkOutput("reset_pending", pend, 0);
    checkOutput("reset_acks", {bus.key_ack, bus.chk_ack, bus.idx_err}, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single KEY set, commit on frame");
    singleReq(0, 2'b00, 4'd3, e);
    checkOutput("list_before_frame", list, 12'h000);
    checkOutput("pending_before_frame", pend, 1);
    framePulse();
    checkOutput("list_bit3", list, 12'h008);
    checkFrame();

    $display("[TB] simultaneous requests and round robin");
    singleReq(0, 2'b11, 4'd0, e);
    applyStimulus(1, 2'b00, 4'd1, 1, 2'b00, 4'd5);
    tick();
    tick();
    checkOutput("rr_chk_first", {bus.key_ack, bus.chk_ack}, 1);
    e = modelApply(2'b00, 4'd5);
    bus.chk_req = 1'b0;
    tick();
    bus.chk_req = 1'b1;
    tick();
    tick();
    checkOutput("rr_key_wins", {bus.key_ack, bus.chk_ack}, 2);
    e = modelApply(2'b00, 4'd1);
    bus.key_req = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("rr_chk_again", {bus.key_ack, bus.chk_ack}, 1);
    e = modelApply(2'b00, 4'd5);
    m_last_chk = 1'b1;
    applyStimulus(0, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    tick();
    framePulse();
    checkOutput("list_0x022", list, 12'h022);
    checkFrame();

    $display("[TB] out-of-range index and clear-all");
    singleReq(0, 2'b10, 4'd14, e);
    checkOutput("toggle14_err", e, 1);
    checkOutput("toggle14_keeps", pend, 0);
    singleReq(0, 2'b11, 4'd15, e);
    checkOutput("clearall15_noerr", e, 0);
    framePulse();
    checkOutput("list_cleared", list, 12'h000);
    checkFrame();

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      singleReq(vecs[i].use_chk, vecs[i].op, vecs[i].idx, e);
      checkOutput($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      framePulse();
      checkOutput($sformatf("vec%0d_list", i), list, vecs[i].exp_mask);
      checkFrame();
    end

    $display("[TB] edit coinciding with frame edge");
    vga_vs = 1'b0;
    tick();
    applyStimulus(1, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    tick();
    tick();
    checkOutput("edge_key_ack", bus.key_ack, 1);
    checkOutput("edge_old_list", list, 12'h804);
    checkOutput("edge_pending", pend, 1);
    m_list = m_shadow;
    m_frames++;
    e = modelApply(2'b00, 4'd0);
    m_last_chk = 1'b0;
    applyStimulus(0, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    repeat (3) tick();
    vga_vs = 1'b1;
    repeat (4) tick();
    framePulse();
    checkOutput("edge_next_list", list, 12'h805);
    checkFrame();

    $display("[TB] blink over several frames");
    for (int i = 0; i < 6; i++) begin
      framePulse();
      checkFrame();
    end

    $display("[TB] reset during WAIT_DROP");
    for (int i = 0; i < NP; i++) singleReq(0, 2'b00, 4'(i), e);
    framePulse();
    checkOutput("list_full", list, 12'hFFF);
    applyStimulus(1, 2'b01, 4'd2, 0, 2'b00, 4'd0);
    tick();
    tick();
    checkOutput("hold_ack", bus.key_ack, 1);
    e = modelApply(2'b01, 4'd2);
    tick();
    checkOutput("hold_no_second_ack", bus.key_ack, 0);
    tick();
    checkOutput("hold_no_second_ack2", bus.key_ack, 0);
    rst_n = 1'b0;
    tick();
    modelReset();
    checkOutput("mid_reset_list", list, 0);
    checkOutput("mid_reset_blink", blink, 0);
    checkOutput("mid_reset_pending", pend, 0);
    checkOutput("mid_reset_acks", {bus.key_ack, bus.chk_ack, bus.idx_err}, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("regrant_not_yet", bus.key_ack, 0);
    tick();
    checkOutput("regrant_ack", bus.key_ack, 1);
    e = modelApply(2'b01, 4'd2);
    m_last_chk = 1'b0;
    checkOutput("regrant_pending", pend, m_shadow != m_list);
    applyStimulus(0, 2'b00, 4'd0, 0, 2'b00, 4'd0);
    tick();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [1:0] op_a, op_b;
      logic [3:0] idx_a, idx_b;
      kind  = $urandom_range(0, 3);
      op_a  = 2'($urandom_range(0, 3));
      op_b  = 2'($urandom_range(0, 3));
      idx_a = 4'($urandom_range(0, 15));
      idx_b = 4'($urandom_range(0, 15));
      case (kind)
        0: singleReq(0, op_a, idx_a, e);
        1: singleReq(1, op_a, idx_a, e);
        2: tieReq(op_a, idx_a, op_b, idx_b);
        default: begin
          framePulse();
          checkFrame();
        end
      endcase
    end
    framePulse();
    checkFrame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
